// File: rtl/mips_dmem_ctrl.sv
// Data memory controller for the MIPS MEM stage: byte/half/word loads and
// stores over a valid/ready request port, fixed wait-state latency, error responses.
module mips_dmem_ctrl #(
  parameter int    DEPTH_LOG2 = 8,
  parameter int    LATENCY    = 1,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is accepted on a rising edge where req_valid and
  // req_ready are both high; req_ready depends on state only. The response is
  // a single-cycle resp_valid strobe with no backpressure.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign dbg_state = state;

  // With zero latency the access happens on the acceptance edge itself, so the
  // operands come straight from the request port while idle.
  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_uns;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic                  go_resp;

  always_comb begin
    if (state == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_uns   = req_unsigned;
      op_addr  = req_addr;
      op_wdata = req_wdata;
    end else begin
      op_we    = r_we;
      op_size  = r_size;
      op_uns   = r_uns;
      op_addr  = r_addr;
      op_wdata = r_wdata;
    end
  end

  assign op_idx  = op_addr[DEPTH_LOG2+1:2];
  assign go_resp = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0));

  logic op_err;
  always_comb begin
    op_err = 1'b0;
    if ((op_addr[31:2] >> DEPTH_LOG2) != 30'd0) op_err = 1'b1;
    case (op_size)
      2'd1:    if (op_addr[0]) op_err = 1'b1;
      2'd2:    if (op_addr[1:0] != 2'd0) op_err = 1'b1;
      2'd3:    op_err = 1'b1;
      default: ;
    endcase
  end

  logic [3:0]  be;
  logic [31:0] wlanes;
  always_comb begin
    be     = 4'b0000;
    wlanes = op_wdata;
    case (op_size)
      2'd0: begin
        be     = 4'b0001 << op_addr[1:0];
        wlanes = {4{op_wdata[7:0]}};
      end
      2'd1: begin
        be     = op_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{op_wdata[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  logic [31:0] word_rd;
  logic [31:0] shifted;
  logic [31:0] load_data;
  always_comb begin
    word_rd   = mem[op_idx];
    shifted   = word_rd >> {op_addr[1:0], 3'b000};
    load_data = 32'd0;
    case (op_size)
      2'd0:    load_data = {{24{~op_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = shifted;
      default: load_data = 32'd0;
    endcase
  end

  // Reset on the commit edge drops the store; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (go_resp && op_we && !op_err && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[op_idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'd0;
      r_uns      <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      if (go_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= op_err;
        resp_rdata <= (op_err || op_we) ? 32'd0 : load_data;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_size    <= req_size;
            r_uns     <= req_unsigned;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// Bench for mips_dmem_ctrl: three instances (LATENCY 0, 1, 5) driven one at a
// time against a word-array reference model of the memory.
module tb_mips_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        vld  [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic        rerr [3];
  logic [31:0] rdat [3];
  logic [1:0]  dbg  [3];

  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;

  int lat_of [3] = '{0, 1, 5};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_dmem_ctrl #(
      .DEPTH_LOG2 (8),
      .LATENCY    ((g == 0) ? 0 : ((g == 1) ? 1 : 5)),
      .INIT_FILE  ("")
    ) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .req_valid    (vld[g]),
      .req_ready    (rdy[g]),
      .req_we       (we),
      .req_size     (size),
      .req_unsigned (uns),
      .req_addr     (addr),
      .req_wdata    (wdata),
      .resp_valid   (rv[g]),
      .resp_rdata   (rdat[g]),
      .resp_err     (rerr[g]),
      .dbg_state    (dbg[g])
    );
  end

  // Scoreboard state
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mdl [3][256];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: memory as an array of words, lanes picked with arithmetic.
  function automatic void ref_access(input int i, input logic w, input logic [1:0] sz,
                                     input logic u, input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
    int unsigned widx = a / 4;
    int unsigned off  = a % 4;
    logic [31:0] word, v, mask;
    er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0) || (widx >= 256);
    rd = 32'd0;
    if (er) return;
    word = mdl[i][widx];
    if (w) begin
      if (sz == 2'd0)      mask = 32'hFF << (8 * off);
      else if (sz == 2'd1) mask = 32'hFFFF << (8 * off);
      else                 mask = 32'hFFFF_FFFF;
      mdl[i][widx] = (word & ~mask) | ((wd << (8 * off)) & mask);
    end else if (sz == 2'd0) begin
      v = (word >> (8 * off)) % 256;
      if (!u && v >= 128) v = v - 32'd256;
      rd = v;
    end else if (sz == 2'd1) begin
      v = (word >> (8 * off)) % 65536;
      if (!u && v >= 32768) v = v - 32'd65536;
      rd = v;
    end else begin
      rd = word;
    end
  endfunction

  task automatic do_req(input int i, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] erd;
    logic        eer;
    int          cyc;
    cyc = 0;
    while (!rdy[i] && cyc < 50) begin @(posedge clk); #1; cyc++; end
    check_eq("ready_wait", 32'(rdy[i]), 32'd1);
    we = w; size = sz; uns = u; addr = a; wdata = wd; vld[i] = 1'b1;
    ref_access(i, w, sz, u, a, wd, erd, eer);
    exp_q.push_back(erd);
    @(posedge clk); #1;
    vld[i] = 1'b0;
    we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    cyc = 0;
    while (!rv[i] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    check_eq("resp_seen", 32'(rv[i]), 32'd1);
    check_eq("latency", 32'(cyc), 32'(lat_of[i]));
    got_rd  = rdat[i];
    got_err = rerr[i];
    check_eq("rdata", rdat[i], exp_q.pop_front());
    check_eq("err", 32'(rerr[i]), 32'(eer));
    @(posedge clk); #1;
    check_eq("pulse_width", 32'(rv[i]), 32'd0);
    check_eq("ready_back", 32'(rdy[i]), 32'd1);
  endtask

  task automatic req_chk(input string tag, input int i, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    do_req(i, w, sz, u, a, wd, rd, er);
    check_eq({tag, "_rd"}, rd, exp_rd);
    check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  task automatic thr(input int i);
    int          l = lat_of[i];
    int          n = 4 * (l + 2);
    int          acc, nresp, last;
    logic [31:0] a, expv;
    a    = 32'($urandom_range(0, 255)) * 4;
    expv = mdl[i][a / 4];
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = a; wdata = $urandom;
    vld[i] = 1'b1;
    acc = 1; nresp = 0; last = -1;
    for (int c = 0; c < n + l + 3; c++) begin
      @(posedge clk); #1;
      if (rv[i]) begin
        nresp++;
        check_eq("thr_rdata", rdat[i], expv);
        if (last >= 0) check_eq("thr_spacing", 32'(c - last), 32'(l + 2));
        last = c;
      end
      if (c < n - 1 && rdy[i]) acc++;
      if (c == n - 1) vld[i] = 1'b0;
    end
    check_eq("thr_accepts", 32'(acc), 32'(n / (l + 2)));
    check_eq("thr_responses", 32'(nresp), 32'(acc));
  endtask

  logic [31:0] t_rd;
  logic        t_er;
  int          pulses;

  initial begin
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; vld[i] = 1'b0; end
    we = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_ready", 32'(rdy[i]), 32'd1);
      check_eq("rst_valid", 32'(rv[i]), 32'd0);
      check_eq("rst_rdata", rdat[i], 32'd0);
      check_eq("rst_err", 32'(rerr[i]), 32'd0);
    end

    // Bring every word to a known value.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 256; w++)
        do_req(i, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, t_rd, t_er);

    req_chk("sw", 1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    req_chk("lw", 1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
    req_chk("sw2", 1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'd0, 1'b0);
    req_chk("lb", 1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
    req_chk("lbu", 1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 32'h00000080, 1'b0);
    req_chk("lh", 1, 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 32'hFFFF80FF, 1'b0);
    req_chk("lhu", 1, 1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 32'h00007F01, 1'b0);
    req_chk("sw3", 1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 32'd0, 1'b0);
    req_chk("sb", 1, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, 32'd0, 1'b0);
    req_chk("sh", 1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, 32'd0, 1'b0);
    req_chk("lw_merge", 1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 32'hBEEFAA44, 1'b0);
    req_chk("e_lw_mis", 1, 1'b0, 2'd2, 1'b0, 32'h2, 32'd0, 32'd0, 1'b1);
    req_chk("sw4", 1, 1'b1, 2'd2, 1'b0, 32'h4, 32'hCAFEF00D, 32'd0, 1'b0);
    req_chk("e_sh_mis", 1, 1'b1, 2'd1, 1'b0, 32'h5, 32'h00001234, 32'd0, 1'b1);
    req_chk("lw_unch", 1, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, 32'hCAFEF00D, 1'b0);
    req_chk("e_range", 1, 1'b0, 2'd2, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
    req_chk("e_size3", 1, 1'b0, 2'd3, 1'b0, 32'h8, 32'd0, 32'd0, 1'b1);

    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 150; k++)
        do_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023)),
               $urandom, t_rd, t_er);

    for (int i = 0; i < 3; i++) thr(i);

    // Store interrupted by reset while waiting must not reach memory.
    req_chk("clr30", 2, 1'b1, 2'd2, 1'b0, 32'h30, 32'd0, 32'd0, 1'b0);
    we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h30; wdata = 32'h12345678; vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    check_eq("mid_rst_ready", 32'(rdy[2]), 32'd1);
    check_eq("mid_rst_valid", 32'(rv[2]), 32'd0);
    check_eq("mid_rst_rdata", rdat[2], 32'd0);
    check_eq("mid_rst_err", 32'(rerr[2]), 32'd0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (rv[2]) pulses++;
    end
    check_eq("mid_rst_no_resp", 32'(pulses), 32'd0);
    req_chk("mid_rst_lw", 2, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
